// File: rtl/tlb_op_ctrl_pkg.sv
// Shared MMU definitions: TLB operation types, MMU response layout and TLB size.
package tlb_op_ctrl_pkg;

    localparam int TLB_ENTRIES = 32;

    typedef enum logic [2:0] {
        TLB_NONE = 3'd0,
        TLBP     = 3'd1,
        TLBR     = 3'd2,
        TLBWI    = 3'd3,
        TLBWR    = 3'd4
    } tlb_type_t;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] entry_hi;
        logic [31:0] entry_lo0;
        logic [31:0] entry_lo1;
    } mmu_resp_t;

    // Probe and read return data to CP0; writes only modify the TLB.
    function automatic logic is_read_op(input tlb_type_t op);
        return (op == TLBP) || (op == TLBR);
    endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random register: counts down each cycle, wrapping to the top entry at or below Wired.
module tlb_random_ctr #(
    parameter int TLB_ENTRIES = tlb_op_ctrl_pkg::TLB_ENTRIES,
    localparam int IW = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] wired,
    input  logic          wired_we,
    output logic [IW-1:0] random_out
);

    localparam logic [IW-1:0] RAND_TOP = IW'(TLB_ENTRIES - 1);

    // A Wired write restarts the range; Wired at the top pins the counter there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            random_out <= RAND_TOP;
        end else if (wired_we || (random_out <= wired)) begin
            random_out <= RAND_TOP;
        end else begin
            random_out <= random_out - IW'(1);
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR instructions between the pipeline, the MMU and CP0.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLB_ENTRIES = tlb_op_ctrl_pkg::TLB_ENTRIES,
    localparam int IW = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  tlb_type_t     req_op,
    input  logic [31:0]   index_in,
    input  logic [31:0]   entry_hi_in,
    input  logic [31:0]   entry_lo0_in,
    input  logic [31:0]   entry_lo1_in,
    input  logic [31:0]   page_mask_in,
    input  logic [IW-1:0] wired,
    input  logic          wired_we,
    input  logic          flush,
    output logic          mmu_req_valid,
    input  logic          mmu_req_ready,
    output tlb_type_t     mmu_req_op,
    output logic [IW-1:0] mmu_req_idx,
    output logic [31:0]   mmu_req_entry_hi,
    output logic [31:0]   mmu_req_entry_lo0,
    output logic [31:0]   mmu_req_entry_lo1,
    output logic [31:0]   mmu_req_page_mask,
    input  logic          mmu_resp_valid,
    input  mmu_resp_t     mmu_resp,
    output tlb_type_t     cp0_wb_type,
    output mmu_resp_t     cp0_wb_resp,
    output logic [IW-1:0] random_out,
    output logic          stall,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    tlb_type_t     op_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] rand_q;
    logic [31:0]   entry_hi_q, entry_lo0_q, entry_lo1_q, page_mask_q;
    mmu_resp_t     resp_q;
    logic          accept, handshake, capture;
    logic          unused_index_hi;

    // Only the low index bits address the TLB; the probe-fail bit lives in the MMU response.
    assign unused_index_hi = ^index_in[31:IW];

    assign accept    = (state == S_IDLE) && req_valid && !flush;
    assign handshake = (state == S_ISSUE) && !flush && mmu_req_ready;
    assign capture   = mmu_resp_valid &&
                       ((state == S_WAIT) || (handshake && is_read_op(op_q)));

    tlb_random_ctr #(.TLB_ENTRIES(TLB_ENTRIES)) u_random (
        .clk        (clk),
        .reset      (reset),
        .wired      (wired),
        .wired_we   (wired_we),
        .random_out (random_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Once the MMU has taken a request the TLB may be modified, so flush no longer aborts.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (mmu_req_ready) begin
                    if (!is_read_op(op_q) || mmu_resp_valid) state_nxt = S_DONE;
                    else                                     state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mmu_resp_valid) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mmu_req_valid = 1'b0;
        stall         = 1'b0;
        done          = 1'b0;
        cp0_wb_type   = TLB_NONE;
        case (state)
            S_IDLE:  stall = req_valid;
            S_ISSUE: begin
                mmu_req_valid = 1'b1;
                stall         = 1'b1;
            end
            S_WAIT:  stall = 1'b1;
            S_DONE: begin
                done = 1'b1;
                if (is_read_op(op_q)) cp0_wb_type = op_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= TLB_NONE;
            idx_q       <= '0;
            rand_q      <= '0;
            entry_hi_q  <= '0;
            entry_lo0_q <= '0;
            entry_lo1_q <= '0;
            page_mask_q <= '0;
            resp_q      <= '0;
        end else begin
            if (accept) begin
                op_q        <= req_op;
                idx_q       <= index_in[IW-1:0];
                rand_q      <= random_out;
                entry_hi_q  <= entry_hi_in;
                entry_lo0_q <= entry_lo0_in;
                entry_lo1_q <= entry_lo1_in;
                page_mask_q <= page_mask_in;
            end
            if (capture) resp_q <= mmu_resp;
        end
    end

    always_comb begin
        case (op_q)
            TLBWI, TLBR: mmu_req_idx = idx_q;
            TLBWR:       mmu_req_idx = rand_q;
            default:     mmu_req_idx = '0;
        endcase
    end

    assign mmu_req_op        = op_q;
    assign mmu_req_entry_hi  = entry_hi_q;
    assign mmu_req_entry_lo0 = entry_lo0_q;
    assign mmu_req_entry_lo1 = entry_lo1_q;
    assign mmu_req_page_mask = page_mask_q;
    assign cp0_wb_resp       = resp_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: directed scenarios with literal expectations plus randomized traffic vs a transaction model.
module tb_tlb_op_ctrl;
    import tlb_op_ctrl_pkg::*;

    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    tlb_type_t     req_op;
    logic [31:0]   index_in, entry_hi_in, entry_lo0_in, entry_lo1_in, page_mask_in;
    logic [IW-1:0] wired;
    logic          wired_we, flush;
    logic          mmu_req_valid, mmu_req_ready;
    tlb_type_t     mmu_req_op;
    logic [IW-1:0] mmu_req_idx;
    logic [31:0]   mmu_req_entry_hi, mmu_req_entry_lo0, mmu_req_entry_lo1, mmu_req_page_mask;
    logic          mmu_resp_valid;
    mmu_resp_t     mmu_resp;
    tlb_type_t     cp0_wb_type;
    mmu_resp_t     cp0_wb_resp;
    logic [IW-1:0] random_out;
    logic          stall, done;

    int checks = 0;
    int errors = 0;

    tlb_op_ctrl #(.TLB_ENTRIES(N)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .index_in(index_in), .entry_hi_in(entry_hi_in), .entry_lo0_in(entry_lo0_in),
        .entry_lo1_in(entry_lo1_in), .page_mask_in(page_mask_in),
        .wired(wired), .wired_we(wired_we), .flush(flush),
        .mmu_req_valid(mmu_req_valid), .mmu_req_ready(mmu_req_ready),
        .mmu_req_op(mmu_req_op), .mmu_req_idx(mmu_req_idx),
        .mmu_req_entry_hi(mmu_req_entry_hi), .mmu_req_entry_lo0(mmu_req_entry_lo0),
        .mmu_req_entry_lo1(mmu_req_entry_lo1), .mmu_req_page_mask(mmu_req_page_mask),
        .mmu_resp_valid(mmu_resp_valid), .mmu_resp(mmu_resp),
        .cp0_wb_type(cp0_wb_type), .cp0_wb_resp(cp0_wb_resp),
        .random_out(random_out), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // An instruction is "in flight" from acceptance until it is reported; "sent" once
    // the MMU has taken it; "reporting" on the single completion cycle.
    int          m_rand;
    bit          m_inflight, m_sent, m_reporting;
    tlb_type_t   m_op;
    logic [31:0] m_index, m_hi, m_lo0, m_lo1, m_pm;
    int          m_rand_at_accept;
    mmu_resp_t   m_resp;

    always @(posedge clk or posedge reset) begin
        int nxt_rand;
        if (reset) begin
            m_rand = N - 1;
            m_inflight = 0; m_sent = 0; m_reporting = 0;
            m_op = TLB_NONE; m_index = 0; m_hi = 0; m_lo0 = 0; m_lo1 = 0; m_pm = 0;
            m_rand_at_accept = 0;
            m_resp = '0;
        end else begin
            nxt_rand = (wired_we || m_rand <= int'(wired)) ? N - 1 : m_rand - 1;
            if (m_reporting) begin
                m_reporting = 0;
            end else if (!m_inflight) begin
                if (req_valid && !flush) begin
                    m_op = req_op; m_index = index_in; m_hi = entry_hi_in;
                    m_lo0 = entry_lo0_in; m_lo1 = entry_lo1_in; m_pm = page_mask_in;
                    m_rand_at_accept = m_rand;
                    m_inflight = 1; m_sent = 0;
                end
            end else if (!m_sent) begin
                if (flush) begin
                    m_inflight = 0;
                end else if (mmu_req_ready) begin
                    if (m_op == TLBWI || m_op == TLBWR) begin
                        m_inflight = 0; m_reporting = 1;
                    end else if (mmu_resp_valid) begin
                        m_resp = mmu_resp; m_inflight = 0; m_reporting = 1;
                    end else begin
                        m_sent = 1;
                    end
                end
            end else if (mmu_resp_valid) begin
                m_resp = mmu_resp; m_inflight = 0; m_sent = 0; m_reporting = 1;
            end
            m_rand = nxt_rand;
        end
    end

    always @(negedge clk) begin
        logic [IW-1:0] e_idx;
        tlb_type_t     e_wb;
        logic [31:0]   idx_word;
        idx_word = m_index;
        if (m_op == TLBWI || m_op == TLBR) e_idx = idx_word[IW-1:0];
        else if (m_op == TLBWR)            e_idx = IW'(m_rand_at_accept);
        else                               e_idx = '0;
        e_wb = (m_reporting && (m_op == TLBP || m_op == TLBR)) ? m_op : TLB_NONE;
        check("m_req_valid", 128'(mmu_req_valid), 128'(m_inflight && !m_sent));
        check("m_done", 128'(done), 128'(m_reporting));
        check("m_stall", 128'(stall), 128'(m_inflight || (!m_reporting && req_valid)));
        check("m_wb_type", 128'(cp0_wb_type), 128'(e_wb));
        check("m_wb_resp", 128'(cp0_wb_resp), 128'(m_resp));
        check("m_random", 128'(random_out), 128'(m_rand));
        check("m_req_op", 128'(mmu_req_op), 128'(m_op));
        check("m_req_idx", 128'(mmu_req_idx), 128'(e_idx));
        check("m_req_fields", {mmu_req_entry_hi, mmu_req_entry_lo0, mmu_req_entry_lo1, mmu_req_page_mask},
              {m_hi, m_lo0, m_lo1, m_pm});
    end

    // ---------------- directed scenarios ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic quiet();
        req_valid = 0; flush = 0; wired_we = 0; mmu_req_ready = 0; mmu_resp_valid = 0;
    endtask

    task automatic wait_random(input int target, input string name);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            if (int'(random_out) == target) begin
                found = 1;
                break;
            end
            tick();
        end
        if (!found) check({name, "_timeout"}, 128'(random_out), 128'(target));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        quiet();
        req_op = TLB_NONE; index_in = 0; entry_hi_in = 0; entry_lo0_in = 0;
        entry_lo1_in = 0; page_mask_in = 0; wired = 3; mmu_resp = '0;
        #1 reset = 1;
        at_neg();
        check("rst_req_valid", 128'(mmu_req_valid), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_stall", 128'(stall), 128'(0));
        check("rst_wb_type", 128'(cp0_wb_type), 128'(TLB_NONE));
        check("rst_wb_resp", 128'(cp0_wb_resp), 128'(0));
        check("rst_random", 128'(random_out), 128'(31));
        tick();
        reset = 0;

        // Random sequence with wired=3: 31 down to 3, period 29.
        for (int k = 0; k < 60; k++) begin
            at_neg();
            check("rand_seq", 128'(random_out), 128'(31 - (k % 29)));
            tick();
        end
        wait_random(10, "rand10");
        wired_we = 1;
        tick();
        wired_we = 0;
        at_neg();
        check("rand_wired_we", 128'(random_out), 128'(31));
        wired = 31;
        tick();
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check("rand_pinned", 128'(random_out), 128'(31));
            tick();
        end
        wired = 3;

        // TLBWI index 5, ready tied high.
        req_valid = 1; req_op = TLBWI; index_in = 5; entry_hi_in = 32'h1234_5000; mmu_req_ready = 1;
        at_neg();
        check("wi_c0_stall", 128'(stall), 128'(1));
        tick();
        req_valid = 0;
        at_neg();
        check("wi_c1_valid", 128'(mmu_req_valid), 128'(1));
        check("wi_c1_idx", 128'(mmu_req_idx), 128'(5));
        check("wi_c1_stall", 128'(stall), 128'(1));
        tick();
        at_neg();
        check("wi_c2_done", 128'(done), 128'(1));
        check("wi_c2_wb", 128'(cp0_wb_type), 128'(TLB_NONE));
        check("wi_c2_stall", 128'(stall), 128'(0));
        tick();
        at_neg();
        check("wi_c3_done", 128'(done), 128'(0));

        // TLBP, response three cycles after the handshake.
        req_valid = 1; req_op = TLBP; entry_hi_in = 32'hABCD_E000;
        tick();
        req_valid = 0;
        at_neg();
        check("p_c1_valid", 128'(mmu_req_valid), 128'(1));
        check("p_c1_idx", 128'(mmu_req_idx), 128'(0));
        tick();
        mmu_req_ready = 0;
        at_neg();
        check("p_wait_stall", 128'(stall), 128'(1));
        check("p_wait_valid", 128'(mmu_req_valid), 128'(0));
        tick();
        at_neg();
        check("p_wait_stall2", 128'(stall), 128'(1));
        tick();
        mmu_resp_valid = 1;
        mmu_resp = '{index: 32'h8000_0000, entry_hi: 32'hABCD_E000, entry_lo0: 32'h11, entry_lo1: 32'h22};
        at_neg();
        check("p_resp_stall", 128'(stall), 128'(1));
        check("p_resp_nodone", 128'(done), 128'(0));
        tick();
        mmu_resp_valid = 0;
        at_neg();
        check("p_done", 128'(done), 128'(1));
        check("p_wb_type", 128'(cp0_wb_type), 128'(TLBP));
        check("p_wb_index", 128'(cp0_wb_resp.index), 128'(32'h8000_0000));
        check("p_done_stall", 128'(stall), 128'(0));
        tick();

        // TLBWR accepted at random=17, ready low for 4 cycles.
        wait_random(17, "rand17");
        req_valid = 1; req_op = TLBWR; entry_lo0_in = 32'h0000_3F17; mmu_req_ready = 0;
        tick();
        req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check("wr_hold_valid", 128'(mmu_req_valid), 128'(1));
            check("wr_hold_idx", 128'(mmu_req_idx), 128'(17));
            check("wr_hold_lo0", 128'(mmu_req_entry_lo0), 128'(32'h0000_3F17));
            tick();
        end
        mmu_req_ready = 1;
        at_neg();
        check("wr_hs_idx", 128'(mmu_req_idx), 128'(17));
        tick();
        mmu_req_ready = 0;
        at_neg();
        check("wr_done", 128'(done), 128'(1));
        check("wr_wb", 128'(cp0_wb_type), 128'(TLB_NONE));
        tick();

        // Flush in ISSUE aborts.
        req_valid = 1; req_op = TLBWI; index_in = 9;
        tick();
        req_valid = 0; flush = 1;
        at_neg();
        check("fl_issue_valid", 128'(mmu_req_valid), 128'(1));
        tick();
        flush = 0;
        at_neg();
        check("fl_drop_valid", 128'(mmu_req_valid), 128'(0));
        check("fl_no_done", 128'(done), 128'(0));
        check("fl_stall", 128'(stall), 128'(0));
        tick();
        at_neg();
        check("fl_no_done2", 128'(done), 128'(0));

        // Flush in WAIT is ignored.
        req_valid = 1; req_op = TLBR; index_in = 7; mmu_req_ready = 1;
        tick();
        req_valid = 0;
        tick();
        mmu_req_ready = 0; flush = 1;
        at_neg();
        check("flw_stall", 128'(stall), 128'(1));
        tick();
        mmu_resp_valid = 1;
        mmu_resp = '{index: 32'd7, entry_hi: 32'h5555_0000, entry_lo0: 32'h33, entry_lo1: 32'h44};
        tick();
        flush = 0; mmu_resp_valid = 0;
        at_neg();
        check("flw_done", 128'(done), 128'(1));
        check("flw_wb_type", 128'(cp0_wb_type), 128'(TLBR));
        check("flw_wb_hi", 128'(cp0_wb_resp.entry_hi), 128'(32'h5555_0000));
        tick();

        // Reset asserted while waiting for a response.
        req_valid = 1; req_op = TLBR; index_in = 2; mmu_req_ready = 1;
        tick();
        req_valid = 0;
        tick();
        mmu_req_ready = 0;
        #2 reset = 1;
        #1;
        check("rw_valid", 128'(mmu_req_valid), 128'(0));
        check("rw_stall", 128'(stall), 128'(0));
        check("rw_done", 128'(done), 128'(0));
        check("rw_wb_type", 128'(cp0_wb_type), 128'(TLB_NONE));
        check("rw_wb_resp", 128'(cp0_wb_resp), 128'(0));
        check("rw_random", 128'(random_out), 128'(31));
        tick();
        reset = 0;
        mmu_resp_valid = 1;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("rw_no_done", 128'(done), 128'(0));
            tick();
        end
        quiet();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 299) == 0);
            req_valid      = ($urandom_range(0, 9) < 4);
            req_op         = tlb_type_t'(3'($urandom_range(1, 4)));
            index_in       = $urandom;
            entry_hi_in    = $urandom;
            entry_lo0_in   = $urandom;
            entry_lo1_in   = $urandom;
            page_mask_in   = $urandom;
            wired          = ($urandom_range(0, 9) == 0) ? IW'($urandom_range(29, 31))
                                                         : IW'($urandom_range(0, 8));
            wired_we       = ($urandom_range(0, 19) == 0);
            flush          = ($urandom_range(0, 19) == 0);
            mmu_req_ready  = ($urandom_range(0, 1) == 1);
            mmu_resp_valid = ($urandom_range(0, 9) < 3);
            mmu_resp.index     = $urandom;
            mmu_resp.entry_hi  = $urandom;
            mmu_resp.entry_lo0 = $urandom;
            mmu_resp.entry_lo1 = $urandom;
            tick();
        end
        reset = 0;
        quiet();
        tick();
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
